rotate_ctrl: RTL and testbench
==============================

ROTATE_CTRL -- requirements
Module: rotate_ctrl

Interface
REQ-001 Parameter BEATS, default 64, SHALL set beats per 8x8 block phase (one READ phase, one WRITE phase).
REQ-002 I_HCLK  in  1  SHALL be the single clock; all state SHALL change on its rising edge.
REQ-003 I_HRESET_N  in  1  SHALL be the asynchronous, active-low reset.
REQ-004 I_REG_START  in  1  SHALL be a one-cycle job start request from the register file.
REQ-005 I_REG_HEIGHT  in  15  SHALL give the source height in pixels.
REQ-006 I_REG_WIDTH  in  14  SHALL give the source width in pixels.
REQ-007 I_REG_DIRECTION  in  1  SHALL select rotation direction (1 = clockwise).
REQ-008 I_REG_DEGREES  in  3  SHALL give the rotation code (0..3 = 0/90/180/270).
REQ-009 I_DMA_READY  in  1  SHALL indicate one beat accepted by the DMA this cycle.
REQ-010 I_ABORT  in  1  SHALL request job termination.
REQ-011 I_IRQ_CLR  in  1  SHALL clear O_IRQ, O_ERR and O_ABORTED.
REQ-012 O_HEIGHT, O_WIDTH, O_DIRECTION, O_DEGREES  out  15/14/1/3  SHALL hold the job configuration latched for the address generator.
REQ-013 O_START  out  1  SHALL pulse one cycle to launch the address generator.
REQ-014 O_BUSY  out  1  SHALL be high in every state except IDLE.
REQ-015 O_PHASE  out  1  SHALL be 0 in READ, 1 in WRITE, 0 otherwise.
REQ-016 O_BLOCKS_LEFT  out  24  SHALL give the 8x8 blocks not yet fully written.
REQ-017 O_DONE  out  1  SHALL pulse one cycle on job completion.
REQ-018 O_IRQ, O_ERR, O_ABORTED  out  1 each  SHALL be sticky status flags.

Function
REQ-019 States SHALL be IDLE, CHECK, LAUNCH, READ, WRITE, DONE.
REQ-020 IDLE: I_REG_START=1 SHALL latch all I_REG_* into O_* config and move to CHECK; I_REG_START in any other state SHALL be ignored.
REQ-021 CHECK (1 cycle): config SHALL be invalid if height=0, width=0, degrees>3, or degrees in {1,3} with height>16383.
REQ-022 CHECK invalid: O_ERR and O_IRQ SHALL set, next state IDLE, O_START never asserted.
REQ-023 CHECK valid: O_BLOCKS_LEFT SHALL load ceil(H/8)*ceil(W/8) (24-bit, no overflow at max 4096*2048); next state LAUNCH.
REQ-024 LAUNCH (1 cycle): O_START=1; next state READ with beat counter 0.
REQ-025 READ/WRITE: beat counter (6-bit) SHALL increment only when I_DMA_READY=1; I_DMA_READY=0 SHALL hold all state.
REQ-026 READ beat BEATS-1 accepted SHALL move to WRITE, beat counter wrapping to 0.
REQ-027 WRITE beat BEATS-1 accepted SHALL decrement O_BLOCKS_LEFT; if it was 1 go DONE, else READ.
REQ-028 DONE (1 cycle): O_DONE=1, O_IRQ set, next state IDLE.
REQ-029 I_ABORT=1 in CHECK/LAUNCH/READ/WRITE SHALL force IDLE next cycle, clear beat counter and O_BLOCKS_LEFT, set O_ABORTED and O_IRQ, no O_DONE; abort SHALL win over a simultaneous final beat; I_ABORT in IDLE/DONE SHALL be ignored.
REQ-030 I_IRQ_CLR coincident with a flag-setting event: set SHALL win.
REQ-031 Latched config SHALL remain stable from CHECK until the next accepted start.

Reset
REQ-032 Reset assertion SHALL immediately force IDLE, all outputs 0, beat counter 0, config registers 0, regardless of state.
REQ-033 Reset release mid-job SHALL NOT resume the job; first start after release SHALL behave as from cold.

Verification
REQ-034 H=16,W=16,deg=1,dir=1, start at cycle 0, I_DMA_READY=1 constant -> CHECK c1, O_START c2, blocks_left 4, 512 beats c3..c514, O_DONE c515, O_IRQ=1.
REQ-035 H=20,W=9 deg=2 -> O_BLOCKS_LEFT=6 after CHECK; I_DMA_READY toggled 50% -> O_DONE after exactly 768 accepted beats.
REQ-036 H=0 or deg=5 or (H=20000,deg=3) -> O_ERR=1, O_IRQ=1, no O_START, O_BUSY low 2 cycles after start; I_IRQ_CLR clears both.
REQ-037 H=8,W=8, I_ABORT at WRITE beat 63 with ready -> IDLE, O_ABORTED=1, no O_DONE, O_BLOCKS_LEFT=0.
REQ-038 Reset asserted mid-READ (beat 30) -> all outputs 0 asynchronously; second I_REG_START during busy ignored; new job after release completes normally.

Source files
------------

// File: rtl/rotate_ctrl_if.sv
// Register-file, DMA and status signals of the rotation job controller.
// The controller takes the slave view; the driver of the job takes the master view.
interface rotate_ctrl_if;
    logic        i_reg_start;
    logic [14:0] i_reg_height;
    logic [13:0] i_reg_width;
    logic        i_reg_direction;
    logic [2:0]  i_reg_degrees;
    logic        i_dma_ready;
    logic        i_abort;
    logic        i_irq_clr;

    logic [14:0] o_height;
    logic [13:0] o_width;
    logic        o_direction;
    logic [2:0]  o_degrees;
    logic        o_start;
    logic        o_busy;
    logic        o_phase;
    logic [23:0] o_blocks_left;
    logic        o_done;
    logic        o_irq;
    logic        o_err;
    logic        o_aborted;

    modport slave (
        input  i_reg_start, i_reg_height, i_reg_width, i_reg_direction, i_reg_degrees,
        input  i_dma_ready, i_abort, i_irq_clr,
        output o_height, o_width, o_direction, o_degrees, o_start, o_busy, o_phase,
        output o_blocks_left, o_done, o_irq, o_err, o_aborted
    );

    modport master (
        output i_reg_start, i_reg_height, i_reg_width, i_reg_direction, i_reg_degrees,
        output i_dma_ready, i_abort, i_irq_clr,
        input  o_height, o_width, o_direction, o_degrees, o_start, o_busy, o_phase,
        input  o_blocks_left, o_done, o_irq, o_err, o_aborted
    );
endinterface

// File: rtl/rotate_ctrl.sv
// Job sequencer for the 8x8-block image rotator: validates the latched configuration,
// launches the address generator and walks READ/WRITE phases until every block is written.
module rotate_ctrl #(
    parameter int BEATS = 64
) (
    input  logic          i_hclk,
    input  logic          i_hreset_n,
    rotate_ctrl_if.slave  bus
);

    localparam int            BW        = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CHECK  = 3'd1,
        S_LAUNCH = 3'd2,
        S_READ   = 3'd3,
        S_WRITE  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t        r_state;
    logic [BW-1:0] r_beat;
    logic [23:0]   r_blocks;
    logic [14:0]   r_height;
    logic [13:0]   r_width;
    logic          r_direction;
    logic [2:0]    r_degrees;
    logic          r_start;
    logic          r_busy;
    logic          r_phase;
    logic          r_done;
    logic          r_irq;
    logic          r_err;
    logic          r_aborted;

    state_t        w_state_nxt;
    logic [BW-1:0] w_beat_nxt;
    logic [23:0]   w_blocks_nxt;
    logic          w_latch;
    logic          w_set_err;
    logic          w_set_irq;
    logic          w_set_abort;
    logic          w_abort_act;
    logic [12:0]   w_hblk;
    logic [11:0]   w_wblk;
    logic [23:0]   w_blocks_calc;

    // Transposing rotations put the height on the 14-bit width axis downstream.
    function automatic logic cfg_invalid(input logic [14:0] h, input logic [13:0] w,
                                         input logic [2:0] deg);
        logic bad;
        bad = 1'b0;
        if (h == 15'd0 || w == 14'd0 || deg > 3'd3) begin
            bad = 1'b1;
        end else if ((deg == 3'd1 || deg == 3'd3) && h > 15'd16383) begin
            bad = 1'b1;
        end else begin
            bad = 1'b0;
        end
        return bad;
    endfunction

    assign w_hblk        = 13'((16'(r_height) + 16'd7) >> 3);
    assign w_wblk        = 12'((15'(r_width) + 15'd7) >> 3);
    assign w_blocks_calc = 24'(w_hblk) * 24'(w_wblk);

    assign w_abort_act = bus.i_abort &&
                         (r_state == S_CHECK || r_state == S_LAUNCH ||
                          r_state == S_READ  || r_state == S_WRITE);

    // State register
    always_ff @(posedge i_hclk or negedge i_hreset_n) begin
        if (!i_hreset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, beat/block counter and flag-event decode
    always_comb begin
        w_state_nxt  = r_state;
        w_beat_nxt   = r_beat;
        w_blocks_nxt = r_blocks;
        w_latch      = 1'b0;
        w_set_err    = 1'b0;
        w_set_irq    = 1'b0;
        w_set_abort  = 1'b0;
        if (w_abort_act) begin
            w_state_nxt  = S_IDLE;
            w_beat_nxt   = '0;
            w_blocks_nxt = 24'd0;
            w_set_abort  = 1'b1;
            w_set_irq    = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.i_reg_start) begin
                        w_latch     = 1'b1;
                        w_state_nxt = S_CHECK;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
                S_CHECK: begin
                    if (cfg_invalid(r_height, r_width, r_degrees)) begin
                        w_set_err   = 1'b1;
                        w_set_irq   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_blocks_nxt = w_blocks_calc;
                        w_state_nxt  = S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    w_beat_nxt  = '0;
                    w_state_nxt = S_READ;
                end
                S_READ: begin
                    if (!bus.i_dma_ready) begin
                        w_state_nxt = S_READ;
                    end else if (r_beat == LAST_BEAT) begin
                        w_beat_nxt  = '0;
                        w_state_nxt = S_WRITE;
                    end else begin
                        w_beat_nxt  = r_beat + BW'(1);
                    end
                end
                S_WRITE: begin
                    if (!bus.i_dma_ready) begin
                        w_state_nxt = S_WRITE;
                    end else if (r_beat == LAST_BEAT) begin
                        w_beat_nxt   = '0;
                        w_blocks_nxt = r_blocks - 24'd1;
                        if (r_blocks == 24'd1) begin
                            w_state_nxt = S_DONE;
                            w_set_irq   = 1'b1;
                        end else begin
                            w_state_nxt = S_READ;
                        end
                    end else begin
                        w_beat_nxt = r_beat + BW'(1);
                    end
                end
                S_DONE: begin
                    w_state_nxt = S_IDLE;
                end
                default: begin
                    w_state_nxt  = S_IDLE;
                    w_beat_nxt   = '0;
                    w_blocks_nxt = 24'd0;
                end
            endcase
        end
    end

    // Beat and block counters
    always_ff @(posedge i_hclk or negedge i_hreset_n) begin
        if (!i_hreset_n) begin
            r_beat   <= '0;
            r_blocks <= 24'd0;
        end else begin
            r_beat   <= w_beat_nxt;
            r_blocks <= w_blocks_nxt;
        end
    end

    // Job configuration, captured only on an accepted start
    always_ff @(posedge i_hclk or negedge i_hreset_n) begin
        if (!i_hreset_n) begin
            r_height    <= 15'd0;
            r_width     <= 14'd0;
            r_direction <= 1'b0;
            r_degrees   <= 3'd0;
        end else if (w_latch) begin
            r_height    <= bus.i_reg_height;
            r_width     <= bus.i_reg_width;
            r_direction <= bus.i_reg_direction;
            r_degrees   <= bus.i_reg_degrees;
        end else begin
            r_height    <= r_height;
            r_width     <= r_width;
            r_direction <= r_direction;
            r_degrees   <= r_degrees;
        end
    end

    // State-decoded outputs, registered from the next state so they align with it
    always_ff @(posedge i_hclk or negedge i_hreset_n) begin
        if (!i_hreset_n) begin
            r_start <= 1'b0;
            r_busy  <= 1'b0;
            r_phase <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_start <= (w_state_nxt == S_LAUNCH);
            r_busy  <= (w_state_nxt != S_IDLE);
            r_phase <= (w_state_nxt == S_WRITE);
            r_done  <= (w_state_nxt == S_DONE);
        end
    end

    // Sticky status flags; a set event beats a coincident clear
    always_ff @(posedge i_hclk or negedge i_hreset_n) begin
        if (!i_hreset_n) begin
            r_irq     <= 1'b0;
            r_err     <= 1'b0;
            r_aborted <= 1'b0;
        end else begin
            r_irq     <= w_set_irq   ? 1'b1 : (bus.i_irq_clr ? 1'b0 : r_irq);
            r_err     <= w_set_err   ? 1'b1 : (bus.i_irq_clr ? 1'b0 : r_err);
            r_aborted <= w_set_abort ? 1'b1 : (bus.i_irq_clr ? 1'b0 : r_aborted);
        end
    end

    assign bus.o_height      = r_height;
    assign bus.o_width       = r_width;
    assign bus.o_direction   = r_direction;
    assign bus.o_degrees     = r_degrees;
    assign bus.o_start       = r_start;
    assign bus.o_busy        = r_busy;
    assign bus.o_phase       = r_phase;
    assign bus.o_blocks_left = r_blocks;
    assign bus.o_done        = r_done;
    assign bus.o_irq         = r_irq;
    assign bus.o_err         = r_err;
    assign bus.o_aborted     = r_aborted;

endmodule

// File: tb/tb_rotate_ctrl.sv
// Scoreboard bench for rotate_ctrl: the driver queues the expected outcome of each job,
// an independent monitor pops and compares on every DONE / ERR / ABORT event.
module tb_rotate_ctrl;
    localparam int BEATS = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rotate_ctrl_if bus ();
    rotate_ctrl #(.BEATS(BEATS)) dut (.i_hclk(clk), .i_hreset_n(rst_n), .bus(bus));

    // kind: 0 = completes, 1 = rejected by CHECK, 2 = aborted by the bench
    typedef struct {
        int          kind;
        int          blocks;
        int          beats;
        logic [14:0] h;
        logic [13:0] w;
        logic        dir;
        logic [2:0]  deg;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   rdy_mode = 0;
    int   last_start_cyc = -1;
    int   last_done_cyc  = -1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    function automatic bit model_valid(input int h, input int w, input int deg);
        if (h == 0 || w == 0 || deg > 3) return 1'b0;
        if ((deg == 1 || deg == 3) && h > 16383) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int model_blocks(input int h, input int w);
        return ((h + 7) / 8) * ((w + 7) / 8);
    endfunction

    // DMA ready pattern: constant, alternating or random
    initial begin
        bus.i_dma_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.i_dma_ready = 1'b1;
                1:       bus.i_dma_ready = ~bus.i_dma_ready;
                default: bus.i_dma_ready = 1'($urandom % 2);
            endcase
        end
    end

    // Monitor: pops expected job outcomes when the DUT reports them
    initial begin
        bit in_rw    = 1'b0;
        int beat_cnt = 0;
        bit prev_err = 1'b0;
        bit prev_ab  = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_rw = 1'b0; beat_cnt = 0; prev_err = 1'b0; prev_ab = 1'b0;
            end else begin
                if (bus.o_start) begin
                    last_start_cyc = cyc;
                    check("start_expected", 64'(sb.size() > 0), 64'd1);
                    if (sb.size() > 0) begin
                        check("start_on_valid", 64'(sb[0].kind != 1), 64'd1);
                        check("blocks_after_check", 64'(bus.o_blocks_left), 64'(sb[0].blocks));
                    end
                    in_rw = 1'b1; beat_cnt = 0;
                end else if (bus.o_done) begin
                    last_done_cyc = cyc;
                    in_rw = 1'b0;
                    check("done_expected", 64'(sb.size() > 0), 64'd1);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        check("done_kind", 64'(e.kind), 64'd0);
                        check("done_beats", 64'(beat_cnt), 64'(e.beats));
                        check("done_blocks_left", 64'(bus.o_blocks_left), 64'd0);
                        check("done_irq", 64'(bus.o_irq), 64'd1);
                        check("cfg_stable", {bus.o_height, bus.o_width, bus.o_direction, bus.o_degrees},
                              {e.h, e.w, e.dir, e.deg});
                    end
                end else if (in_rw && bus.o_busy && bus.i_dma_ready) begin
                    beat_cnt++;
                end
                if (bus.o_err && !prev_err) begin
                    check("err_expected", 64'(sb.size() > 0), 64'd1);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        check("err_kind", 64'(e.kind), 64'd1);
                        check("err_irq", 64'(bus.o_irq), 64'd1);
                    end
                end
                if (bus.o_aborted && !prev_ab) begin
                    in_rw = 1'b0;
                    check("abort_expected", 64'(sb.size() > 0), 64'd1);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        check("abort_kind", 64'(e.kind), 64'd2);
                        check("abort_blocks_left", 64'(bus.o_blocks_left), 64'd0);
                        check("abort_idle", 64'(bus.o_busy), 64'd0);
                        check("abort_irq", 64'(bus.o_irq), 64'd1);
                    end
                end
                prev_err = bus.o_err;
                prev_ab  = bus.o_aborted;
            end
        end
    end

    task automatic start_job(input int h, input int w, input int dir, input int deg,
                             input bit will_abort, output int t0);
        exp_t e;
        @(posedge clk);
        #1;
        bus.i_reg_height    = 15'(h);
        bus.i_reg_width     = 14'(w);
        bus.i_reg_direction = 1'(dir);
        bus.i_reg_degrees   = 3'(deg);
        bus.i_reg_start     = 1'b1;
        t0 = cyc;
        e.kind   = will_abort ? 2 : (model_valid(h, w, deg) ? 0 : 1);
        e.blocks = model_blocks(h, w);
        e.beats  = e.blocks * 2 * BEATS;
        e.h = 15'(h); e.w = 14'(w); e.dir = 1'(dir); e.deg = 3'(deg);
        sb.push_back(e);
        @(posedge clk);
        #1 bus.i_reg_start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!bus.o_busy) begin ok = 1'b1; break; end
        end
        check({name, "_idle_timeout"}, 64'(ok), 64'd1);
    endtask

    task automatic wait_start(input int budget, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.o_start) begin ok = 1'b1; break; end
        end
        check({name, "_start_timeout"}, 64'(ok), 64'd1);
    endtask

    task automatic abort_after(input int n, input bit expect_write);
        repeat (n) @(posedge clk);
        #1;
        if (expect_write) check("abort_in_write_phase", 64'(bus.o_phase), 64'd1);
        bus.i_abort = 1'b1;
        @(posedge clk);
        #1 bus.i_abort = 1'b0;
    endtask

    task automatic clear_irq(input string name);
        @(posedge clk);
        #1 bus.i_irq_clr = 1'b1;
        @(posedge clk);
        #1 bus.i_irq_clr = 1'b0;
        @(negedge clk);
        check({name, "_flags_cleared"}, {61'd0, bus.o_irq, bus.o_err, bus.o_aborted}, 64'd0);
    endtask

    task automatic check_all_zero(input string name);
        check(name, {bus.o_height, bus.o_width, bus.o_direction, bus.o_degrees, bus.o_start,
                     bus.o_busy, bus.o_phase, bus.o_blocks_left, bus.o_done, bus.o_irq,
                     bus.o_err, bus.o_aborted}, 64'd0);
    endtask

    initial begin
        int t0;
        int h, w, deg;
        bus.i_reg_start = 1'b0; bus.i_reg_height = 15'd0; bus.i_reg_width = 14'd0;
        bus.i_reg_direction = 1'b0; bus.i_reg_degrees = 3'd0;
        bus.i_abort = 1'b0; bus.i_irq_clr = 1'b0;

        #12 check_all_zero("reset_outputs");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Reference timing job with constant ready
        rdy_mode = 0;
        start_job(16, 16, 1, 1, 1'b0, t0);
        wait_idle(2000, "ref_job");
        check("ref_start_cycle", 64'(last_start_cyc - t0), 64'd2);
        check("ref_done_cycle", 64'(last_done_cyc - t0), 64'd515);
        check("ref_irq_sticky", 64'(bus.o_irq), 64'd1);
        clear_irq("ref_job");

        // Clear held across the DONE set event
        bus.i_irq_clr = 1'b1;
        start_job(8, 8, 0, 0, 1'b0, t0);
        wait_idle(500, "clr_hold");
        bus.i_irq_clr = 1'b0;

        // Alternating ready, 3x2 blocks
        rdy_mode = 1;
        start_job(20, 9, 0, 2, 1'b0, t0);
        wait_idle(4000, "half_ready");
        clear_irq("half_ready");

        // Rejected configurations
        rdy_mode = 0;
        for (int k = 0; k < 4; k++) begin
            case (k)
                0:       begin h = 0;     w = 16; deg = 1; end
                1:       begin h = 16;    w = 16; deg = 5; end
                2:       begin h = 20000; w = 16; deg = 3; end
                default: begin h = 16384; w = 8;  deg = 1; end
            endcase
            start_job(h, w, 0, deg, 1'b0, t0);
            @(negedge clk);
            check("bad_busy_in_check", 64'(bus.o_busy), 64'd1);
            @(negedge clk);
            check("bad_busy_after", 64'(bus.o_busy), 64'd0);
            check("bad_err_irq", {62'd0, bus.o_err, bus.o_irq}, 64'd3);
            clear_irq("bad_cfg");
        end

        // Largest valid transposing height, then largest overall, both aborted in READ
        start_job(16383, 8, 1, 3, 1'b1, t0);
        wait_start(10, "big_t");
        abort_after(5, 1'b0);
        wait_idle(20, "big_t");
        clear_irq("big_t");
        start_job(32767, 16383, 0, 0, 1'b1, t0);
        wait_start(10, "max");
        abort_after(3, 1'b0);
        wait_idle(20, "max");
        clear_irq("max");

        // Abort coinciding with the final WRITE beat of a single-block job
        start_job(8, 8, 0, 0, 1'b1, t0);
        wait_start(10, "last_beat_abort");
        abort_after(128, 1'b1);
        wait_idle(20, "last_beat_abort");
        check("abort_no_done", 64'(last_done_cyc > last_start_cyc), 64'd0);
        clear_irq("last_beat_abort");

        // A second start while busy must be ignored
        rdy_mode = 2;
        start_job(8, 16, 1, 2, 1'b0, t0);
        wait_start(10, "busy_start");
        repeat (4) @(posedge clk);
        #1;
        bus.i_reg_height = 15'd40; bus.i_reg_width = 14'd40; bus.i_reg_start = 1'b1;
        @(posedge clk);
        #1 bus.i_reg_start = 1'b0;
        wait_idle(2000, "busy_start");
        clear_irq("busy_start");

        // Asynchronous reset around READ beat 30, then a fresh job
        rdy_mode = 0;
        start_job(16, 16, 1, 1, 1'b0, t0);
        wait_start(10, "mid_reset");
        repeat (32) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_all_zero("async_reset_outputs");
        sb.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        start_job(8, 8, 0, 1, 1'b0, t0);
        wait_idle(500, "post_reset");
        check("post_reset_start_cycle", 64'(last_start_cyc - t0), 64'd2);
        clear_irq("post_reset");

        // Random jobs under random ready
        rdy_mode = 2;
        for (int k = 0; k < 10; k++) begin
            h   = $urandom_range(1, 24);
            w   = $urandom_range(1, 24);
            deg = $urandom_range(0, 4);
            start_job(h, w, int'($urandom % 2), deg, 1'b0, t0);
            wait_idle(6000, "rand");
            clear_irq("rand");
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
